bcd_timer_ctrl: RTL
===================

Name: bcd_timer_ctrl

Overview:
Sequencing controller for a chain of NUM_DIGITS single-digit BCD up/down counters that together form a multi-digit timer or stopwatch. It prescales the system clock into count ticks and generates per-digit cascade enables from the digit values it reads back. It also drives the chain's load, clear and direction controls, and runs an IDLE/LOAD/RUN/PAUSE/DONE state machine with a terminal-count flag. It sits between the user-facing button/switch logic and the digit counters that feed the display mux.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits (1..8); digit 0 is least significant.
PRESCALE, 100000, clk1 cycles per count tick (>=1; 1 means a tick every RUN cycle).

Ports:
clk1  in  1  system clock, all state on rising edge.
rst1  in  1  asynchronous, active-low reset.
start  in  1  level; IDLE/PAUSE -> RUN.
pause  in  1  level; RUN -> PAUSE.
clear  in  1  synchronous clear request, highest priority.
load_req  in  1  capture preset and load it into the chain.
mode_down  in  1  0 = count up, 1 = count down; sampled only on LOAD and clear.
preset  in  4*NUM_DIGITS  BCD preset, digit i at [4i+3:4i].
dig_q  in  4*NUM_DIGITS  current digit values read back from the chain.
dig_en  out  NUM_DIGITS  per-digit count enable, combinational.
dig_load  out  1  one-cycle load strobe to all digits.
dig_clr  out  1  one-cycle clear strobe to all digits.
dig_ud  out  1  direction to all digits (1 = down).
dig_d  out  4*NUM_DIGITS  latched preset driven to the chain's load inputs.
busy  out  1  high in RUN or PAUSE.
done  out  1  high in DONE (level).
state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

Behaviour:
- Reset (rst1=0): state=IDLE; dig_d=0, dig_ud=0, dig_load=0, dig_clr=0, prescaler=0; dig_en=0, busy=0, done=0. Effective immediately, without waiting for a clock edge.
- Command priority each cycle: clear > load_req > pause > start.
- clear, any state: next state IDLE, dig_clr=1 for one cycle, dig_ud<=mode_down, prescaler<=0. A digit clear forces 0 when counting up and 9 when counting down.
- load_req, not clear: dig_d<=preset, dig_ud<=mode_down, next state LOAD. LOAD asserts dig_load for exactly one cycle, then moves to IDLE. dig_q reflects the preset one cycle after the LOAD cycle.
- IDLE: start -> RUN.
- RUN: pause -> PAUSE; otherwise the prescaler increments.
  - tick = RUN && prescaler==PRESCALE-1; the prescaler wraps to 0 on tick.
- PAUSE: prescaler holds its value; start && !pause -> RUN and counting resumes mid-period.
- Cascade: dig_en[0]=tick. dig_en[i]=tick && every digit j<i is at terminal value: 9 if dig_ud=0, 0 if dig_ud=1. dig_en is 0 outside RUN.
- Terminal detect: all digits 9 (up) or all digits 0 (down), evaluated on dig_q.
  - Terminal seen in RUN: next state DONE, no dig_en issued that cycle, so no wrap.
  - Terminal seen on entry to RUN: DONE next cycle with zero enables.
- DONE: done=1, dig_en=0; exits only on clear or load_req.
- Digit values are assumed BCD-legal. Non-BCD digits (>9) are never terminal and take no special handling.
- dig_ud changes only in the clear or load_req cycle; it never changes in RUN.

Optional Feature:
AUTO_RELOAD_EN. When defined, a down-mode terminal in RUN does not enter DONE. Instead:
- dig_load pulses for one cycle with the held dig_d and the block stays in RUN.
- done pulses high for that same single cycle.
- The prescaler keeps running, so the period between reloads is exact.
Up mode is unchanged. Without the macro, down mode stops in DONE as described above.

Test Plan:
NUM_DIGITS=2, PRESCALE=4, hold rst1=0 -> all outputs 0, state=0; release -> state stays 0.
Up count: clear (mode_down=0), start -> dig_en[0] pulses every 4th cycle; dig_en[1] pulses only when dig_q[3:0]=9; at dig_q=8'h99 -> DONE, done=1, no further dig_en.
Down count: preset=8'h10, load_req, then start -> dig_load one cycle; ticks give 10,09,...,00 with dig_en[1] only on the 10->09 tick; DONE at 00. With AUTO_RELOAD_EN: dig_load pulses at 00, done pulses one cycle, counting continues from 10.
Pause mid-period: pause after 2 RUN cycles, hold 10 cycles, resume -> next tick arrives 2 cycles after resume; no dig_en while paused.
Priority: clear and load_req asserted together in RUN -> dig_clr=1, dig_load=0, state=IDLE.
Async reset mid-RUN: rst1 dropped between edges -> state=0 and dig_en=0 immediately, before the next clk1 edge.

Source files
------------

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a cascaded BCD up/down digit chain: prescaler, cascade enables,
// IDLE/LOAD/RUN/PAUSE/DONE state machine. Optional macro AUTO_RELOAD_EN: down-mode terminal reloads.
module bcd_timer_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 100000
) (
   input  logic                    clk1,
   input  logic                    rst1,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    clear,
   input  logic                    load_req,
   input  logic                    mode_down,
   input  logic [4*NUM_DIGITS-1:0] preset,
   input  logic [4*NUM_DIGITS-1:0] dig_q,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    dig_load,
   output logic                    dig_clr,
   output logic                    dig_ud,
   output logic [4*NUM_DIGITS-1:0] dig_d,
   output logic                    busy,
   output logic                    done,
   output logic [2:0]              state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   state_t                cur, nxt;
   logic [PW-1:0]         pre;
   logic [NUM_DIGITS-1:0] at_term;
   logic                  all_term;
   logic                  run_ok;
   logic                  tick;
   logic                  reload_hit;
   logic                  carry;
   logic [3:0]            term_val;

   // Terminal digit value depends on the latched direction, not the live switch.
   assign term_val = dig_ud ? 4'd0 : 4'd9;

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         at_term[i] = (dig_q[4*i +: 4] == term_val);
      end
   end

   assign all_term = &at_term;
   assign run_ok   = (cur == RUN) && !clear && !load_req && !pause;
   assign tick     = run_ok && (pre == PMAX);

`ifdef AUTO_RELOAD_EN
   assign reload_hit = run_ok && all_term && dig_ud;
`else
   assign reload_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk1 or negedge rst1) begin
      if (!rst1) begin
         cur <= IDLE;
      end else begin
         cur <= nxt;
      end
   end

   always_ff @(posedge clk1 or negedge rst1) begin
      if (!rst1) begin
         pre     <= '0;
         dig_d   <= '0;
         dig_ud  <= 1'b0;
         dig_clr <= 1'b0;
      end else begin
         dig_clr <= clear;
         if (clear) begin
            pre    <= '0;
            dig_ud <= mode_down;
         end else if (load_req) begin
            dig_d  <= preset;
            dig_ud <= mode_down;
         end else if (run_ok) begin
            pre <= tick ? '0 : pre + 1'b1;
         end
      end
   end

   // NOTE: nxt gets a default first so no path through the case can infer a latch.
   always_comb begin
      nxt = cur;
      if (clear) begin
         nxt = IDLE;
      end else if (load_req) begin
         nxt = LOAD;
      end else begin
         unique case (cur)
            IDLE:  if (start) nxt = RUN;
            LOAD:  nxt = IDLE;
            RUN: begin
               if (pause) nxt = PAUSE;
               else if (all_term && !reload_hit) nxt = DONE;
            end
            PAUSE: if (start && !pause) nxt = RUN;
            DONE:  nxt = DONE;
            default: nxt = IDLE;
         endcase
      end
   end

   // Enables ripple up only through digits sitting at their terminal value; none once terminal.
   always_comb begin
      dig_en = '0;
      carry  = tick && !all_term;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dig_en[i] = carry;
         carry     = carry && at_term[i];
      end
      dig_load = (cur == LOAD) || reload_hit;
      done     = (cur == DONE) || reload_hit;
      busy     = (cur == RUN) || (cur == PAUSE);
   end

   assign state = cur;

endmodule
